// File: rtl/data_ram.sv
// rtl/data_ram.sv - byte-addressed read/write data memory with split access for word-spanning loads/stores
module data_ram #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       out
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int WA    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {IDLE, SECOND} state_t;

    state_t state;

    logic [31:0] mem [WORDS];

    logic [2:0]        n_bytes;
    logic [3:0]        nmask;
    logic [ADDR_W:0]   last_byte;
    logic              illegal;
    logic              spans;
    logic [WA-1:0]     widx;
    logic [7:0]        lane_mask;
    logic [63:0]       lane_data;
    logic              accept;
    logic              store_lo;
    logic              store_hi;
    logic [31:0]       lo_raw;
    logic [31:0]       split_raw;

    // state latched at the first edge of a split access
    logic [31:0]       hold;
    logic [WA-1:0]     l_widx_next;
    logic [1:0]        l_off;
    logic [1:0]        l_size;
    logic              l_sext;
    logic              l_we;
    logic [3:0]        l_hi_mask;
    logic [31:0]       l_hi_data;

    // access width in bytes and as a lane mask starting at lane 0
    always_comb begin
        n_bytes = 3'd4;
        nmask   = 4'b1111;
        case (size)
            2'b00:   begin n_bytes = 3'd1; nmask = 4'b0001; end
            2'b01:   begin n_bytes = 3'd2; nmask = 4'b0011; end
            default: begin n_bytes = 3'd4; nmask = 4'b1111; end
        endcase
    end

    // one extra bit so the last-byte address never wraps
    assign last_byte = {1'b0, addr} + (ADDR_W+1)'(n_bytes) - (ADDR_W+1)'(1);
    assign illegal   = (size == 2'b11) || (last_byte > (ADDR_W+1)'(DEPTH_BYTES - 1));
    assign spans     = ({1'b0, addr[1:0]} + n_bytes) > 3'd4;
    assign widx      = addr[WA+1:2];

    // lanes/data over a two-word window; the upper word is only used when spanning
    assign lane_mask = {4'b0000, nmask} << addr[1:0];
    assign lane_data = {32'b0, wdata} << {addr[1:0], 3'b000};

    assign accept   = (state == IDLE) && req;
    assign store_lo = accept && !illegal && we;
    assign store_hi = (state == SECOND) && l_we;

    assign lo_raw    = mem[widx] >> {addr[1:0], 3'b000};
    assign split_raw = 32'({mem[l_widx_next], hold} >> {l_off, 3'b000});

    function automatic logic [31:0] extend(input logic [31:0] r, input logic [1:0] sz, input logic sx);
        case (sz)
            2'b00:   extend = {{24{sx & r[7]}}, r[7:0]};
            2'b01:   extend = {{16{sx & r[15]}}, r[15:0]};
            default: extend = r;
        endcase
    endfunction

    // byte-lane writes: first word at acceptance, remaining lanes of the next word in SECOND
    always_ff @(posedge clk) begin
        if (store_lo) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_mask[l]) mem[widx][8*l +: 8] <= lane_data[8*l +: 8];
            end
        end
        if (store_hi) begin
            for (int l = 0; l < 4; l++) begin
                if (l_hi_mask[l]) mem[l_widx_next][8*l +: 8] <= l_hi_data[8*l +: 8];
            end
        end
    end

    // access control FSM with registered busy/done/err/out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            out         <= 32'd0;
            hold        <= 32'd0;
            l_widx_next <= '0;
            l_off       <= 2'd0;
            l_size      <= 2'd0;
            l_sext      <= 1'b0;
            l_we        <= 1'b0;
            l_hi_mask   <= 4'd0;
            l_hi_data   <= 32'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (illegal) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else if (spans) begin
                            hold        <= mem[widx];
                            l_widx_next <= widx + WA'(1);
                            l_off       <= addr[1:0];
                            l_size      <= size;
                            l_sext      <= sign_ext;
                            l_we        <= we;
                            l_hi_mask   <= lane_mask[7:4];
                            l_hi_data   <= lane_data[63:32];
                            state       <= SECOND;
                            busy        <= 1'b1;
                        end else begin
                            if (!we) out <= extend(lo_raw, size, sign_ext);
                            done <= 1'b1;
                        end
                    end
                end
                SECOND: begin
                    if (!l_we) out <= extend(split_raw, l_size, l_sext);
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// tb/tb_data_ram.sv - randomized self-checking bench for data_ram against a byte-array model
module tb_data_ram;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  mb [1024];
    logic [31:0] exp_out;

    data_ram #(.DEPTH_BYTES(1024), .ADDR_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .out      (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input logic sx);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = mb[int'(a) + k];
        if (n == 1) return sx ? {{24{r[7]}}, r[7:0]} : {24'd0, r[7:0]};
        if (n == 2) return sx ? {{16{r[15]}}, r[15:0]} : {16'd0, r[15:0]};
        return r;
    endfunction

    // one access; poke re-drives req with scrambled inputs while busy
    task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input logic poke);
        int     n;
        longint last;
        logic   ill;
        logic   spn;
        n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        last = longint'(a) + longint'(n) - 1;
        ill  = (sz == 2'b11) || (last > 1023);
        spn  = !ill && ((int'(a[1:0]) + n) > 4);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        req = 1'b0;
        if (!ill) begin
            if (w) begin
                for (int k = 0; k < n; k++) mb[int'(a) + k] = wd[8*k +: 8];
            end else begin
                exp_out = model_load(a, n, sx);
            end
        end
        if (spn) begin
            check("busy_split", {31'd0, busy}, 32'd1);
            check("done_early", {31'd0, done}, 32'd0);
            if (poke) begin
                @(negedge clk);
                req = 1'b1; we = ~w; addr = $urandom; wdata = $urandom;
                size = 2'($urandom_range(0, 3)); sign_ext = ~sx;
            end
            @(posedge clk);
            #1;
            req = 1'b0;
        end
        check("done", {31'd0, done}, 32'd1);
        check("err", {31'd0, err}, {31'd0, ill});
        check("busy_end", {31'd0, busy}, 32'd0);
        check("out", out, exp_out);
        if (spn && poke) begin
            @(posedge clk);
            #1;
            check("no_extra_done", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a;
        req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = 32'd0; wdata = 32'd0;
        exp_out = 32'd0;
        for (int i = 0; i < 1024; i++) mb[i] = 8'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err",  {31'd0, err},  32'd0);
        check("rst_out",  out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // establish known contents independent of simulator power-up values
        for (int i = 0; i < 256; i++) access(1'b1, 2'b10, 1'b0, 32'(i * 4), 32'd0, 1'b0);

        // aligned word
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        check("word_aligned", out, 32'hDEADBEEF);

        // byte lanes and extension
        access(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000080, 1'b0);
        access(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b0);
        check("byte_sext", out, 32'hFFFFFF80);
        access(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b0);
        check("byte_zext", out, 32'h00000080);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        check("byte_lane", out, 32'h00008000);

        // spanning word
        access(1'b1, 2'b10, 1'b0, 32'h33, 32'h11223344, 1'b0);
        check("store_keeps_out", out, 32'h00008000);
        access(1'b0, 2'b10, 1'b0, 32'h33, 32'h0, 1'b0);
        check("span_word", out, 32'h11223344);
        access(1'b0, 2'b00, 1'b0, 32'h36, 32'h0, 1'b0);
        check("span_byte36", out, 32'h00000011);

        // spanning half with ignored requests while busy
        access(1'b1, 2'b01, 1'b0, 32'h37, 32'h0000A5B6, 1'b1);
        access(1'b0, 2'b01, 1'b1, 32'h37, 32'h0, 1'b1);
        check("span_half", out, 32'hFFFFA5B6);

        // errors and top boundary
        access(1'b1, 2'b11, 1'b0, 32'h50, 32'hFFFFFFFF, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 1'b0);
        check("illegal_no_write", out, 32'h0);
        access(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'd1021, 32'h0, 1'b0);
        check("err_out_hold", out, 32'h00000080);
        access(1'b1, 2'b00, 1'b0, 32'd1023, 32'h0000005A, 1'b0);
        access(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h1234, 1'b0);
        access(1'b0, 2'b00, 1'b0, 32'd1023, 32'h0, 1'b0);
        check("top_byte", out, 32'h0000005A);

        // reset during SECOND of a spanning store
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h3E; wdata = 32'hCAFEBABE;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
        mb[32'h3E] = 8'hBE;
        mb[32'h3F] = 8'hBA;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_out = 32'd0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_out", out, 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid_done2", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0:       a = $urandom;
                1:       a = 32'($urandom_range(1016, 1023));
                default: a = 32'($urandom_range(0, 1023));
            endcase
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
